// File: rtl/a2d_spi_resp.sv
// SPI responder for an eight-channel A/D sample bank: a 16-bit command frame selects
// the channel, and the sample for the previously selected channel is shifted out.
module a2d_spi_resp #(
   parameter logic [2:0] FIRST_CH = 3'b000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [95:0] chan_data,
   output logic [2:0]  cmd_ch,
   output logic        cmd_vld,
   output logic        frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      SHIFT
   } state_t;

   state_t      state, state_n;
   logic [2:0]  ss_sync, sclk_sync, mosi_sync;
   logic [1:0]  sync_ok;
   logic [15:0] rx, rx_n;
   logic [15:0] tx, tx_n;
   logic [4:0]  cnt, cnt_n;
   logic [2:0]  cmd_ch_n;
   logic        vld_n, err_n, miso_n;
   logic [11:0] sample;
   logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

   assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
   assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
   assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
   assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];

   always_comb begin
      sample = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (cmd_ch == i[2:0])
            sample = chan_data[12*i +: 12];
      end
   end

   always_comb begin
      state_n  = state;
      rx_n     = rx;
      tx_n     = tx;
      cnt_n    = cnt;
      cmd_ch_n = cmd_ch;
      vld_n    = 1'b0;
      err_n    = 1'b0;
      case (state)
         IDLE: begin
            // sync_ok holds IDLE until the synchronizer carries real SS_n samples,
            // not its reset fill, so a frame live at reset release is skipped.
            if (sync_ok[1] && ss_sync[1])
               state_n = ARMED;
         end
         ARMED: begin
            if (ss_fall) begin
               state_n = SHIFT;
               tx_n    = {4'h0, sample};
               rx_n    = '0;
               cnt_n   = '0;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_n = ARMED;
               if (cnt == 5'd16 && rx[15:14] == 2'b00) begin
                  cmd_ch_n = rx[13:11];
                  vld_n    = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end else if (sclk_rise) begin
               rx_n = {rx[14:0], mosi_sync[2]};
               if (cnt != 5'd17)
                  cnt_n = cnt + 5'd1;
            end else if (sclk_fall && cnt != 5'd0) begin
               tx_n = {tx[14:0], 1'b0};
            end
         end
         default: state_n = IDLE;
      endcase
      miso_n = (state_n == SHIFT) ? tx_n[15] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ss_sync   <= '1;
         sclk_sync <= '1;
         mosi_sync <= '0;
         sync_ok   <= '0;
         state     <= IDLE;
         rx        <= '0;
         tx        <= '0;
         cnt       <= '0;
         cmd_ch    <= FIRST_CH;
         cmd_vld   <= 1'b0;
         frame_err <= 1'b0;
         MISO      <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[1:0], SS_n};
         sclk_sync <= {sclk_sync[1:0], SCLK};
         mosi_sync <= {mosi_sync[1:0], MOSI};
         sync_ok   <= {sync_ok[0], 1'b1};
         state     <= state_n;
         rx        <= rx_n;
         tx        <= tx_n;
         cnt       <= cnt_n;
         cmd_ch    <= cmd_ch_n;
         cmd_vld   <= vld_n;
         frame_err <= err_n;
         MISO      <= miso_n;
      end
   end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Scoreboard bench for a2d_spi_resp: frames are driven over SPI, the expected
// response word and command outcome are queued, then popped and compared.
module tb_a2d_spi_resp;

   logic        clk = 1'b0;
   logic        rst_n, SS_n, SCLK, MOSI;
   logic        MISO;
   logic [95:0] chan_data;
   logic [2:0]  cmd_ch;
   logic        cmd_vld, frame_err;

   a2d_spi_resp #(.FIRST_CH(3'b000)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .chan_data(chan_data), .cmd_ch(cmd_ch),
      .cmd_vld(cmd_vld), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] mosi;
      int          nrise;
      int          chg_at;
      int          chg_ch;
      logic [11:0] chg_v;
      logic [15:0] miso;
      logic [15:0] mask;
      logic        vld;
      logic [2:0]  ch;
   } vec_t;

   vec_t sb[$];
   int   n_vec = 0, n_bad = 0;
   int   vld_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
   logic prev_vld = 1'b0, prev_err = 1'b0;

   always @(negedge clk) begin
      if (cmd_vld) vld_cnt <= vld_cnt + 1;
      if (frame_err) err_cnt <= err_cnt + 1;
      if (cmd_vld && frame_err) both_cnt <= both_cnt + 1;
      if ((cmd_vld && prev_vld) || (frame_err && prev_err)) long_cnt <= long_cnt + 1;
      prev_vld <= cmd_vld;
      prev_err <= frame_err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic set_ch(input int c, input logic [11:0] v);
      chan_data[12*c +: 12] = v;
   endtask

   task automatic sclk_cycle();
      SCLK = 1'b0; tick(6);
      SCLK = 1'b1; tick(6);
   endtask

   // Drives one frame; returns captured MISO word, cycles from SS_n rise to pulse.
   task automatic spi_frame(input vec_t v, output logic [15:0] rw, output int lat,
                            output logic gv, output logic ge);
      rw = '0;
      tick(1);
      SS_n = 1'b0;
      MOSI = v.mosi[15];
      tick(6);
      for (int i = 0; i < v.nrise; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? v.mosi[15-i] : 1'b0;
         tick(6);
         if (i < 16) rw[15-i] = MISO;
         if (i == v.chg_at) set_ch(v.chg_ch, v.chg_v);
         SCLK = 1'b1;
         tick(6);
      end
      SS_n = 1'b1;
      lat = -1; gv = 1'b0; ge = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (cmd_vld || frame_err) begin
            lat = k; gv = cmd_vld; ge = frame_err;
            break;
         end
      end
      tick(4);
   endtask

   task automatic run_table(input string tag, input vec_t tab[]);
      logic [15:0] rw;
      int          lat;
      logic        gv, ge;
      vec_t        e;
      foreach (tab[i]) begin
         sb.push_back(tab[i]);
         spi_frame(tab[i], rw, lat, gv, ge);
         e = sb.pop_front();
         n_vec++;
         if ((rw & e.mask) !== (e.miso & e.mask)) begin
            n_bad++;
            $display("FAIL %s[%0d] miso got %h want %h", tag, i, rw & e.mask, e.miso & e.mask);
         end
         n_vec++;
         if ({gv, ge} !== {e.vld, ~e.vld}) begin
            n_bad++;
            $display("FAIL %s[%0d] vld/err got %b%b want %b%b", tag, i, gv, ge, e.vld, ~e.vld);
         end
         n_vec++;
         if (cmd_ch !== e.ch) begin
            n_bad++;
            $display("FAIL %s[%0d] cmd_ch got %0d want %0d", tag, i, cmd_ch, e.ch);
         end
         n_vec++;
         if (lat !== 4) begin
            n_bad++;
            $display("FAIL %s[%0d] latency got %0d want 4", tag, i, lat);
         end
         n_vec++;
         if (MISO !== 1'b0) begin
            n_bad++;
            $display("FAIL %s[%0d] idle MISO got %b want 0", tag, i, MISO);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      tick(5);
      n_vec++;
      if ({MISO, cmd_vld, frame_err} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset outputs got %b want 000", {MISO, cmd_vld, frame_err});
      end
      n_vec++;
      if (cmd_ch !== 3'd0) begin
         n_bad++;
         $display("FAIL reset cmd_ch got %0d want 0", cmd_ch);
      end
      rst_n = 1'b1;
      tick(8);
   endtask

   task automatic test_command();
      vec_t tab[] = '{
         '{16'h2000, 16, -1, 0, 12'h0, 16'h0ABC, 16'hFFFF, 1'b1, 3'd4},
         '{16'h2800, 16, -1, 0, 12'h0, 16'h0123, 16'hFFFF, 1'b1, 3'd5}};
      run_table("command", tab);
   endtask

   task automatic test_abort();
      vec_t tab[] = '{
         '{16'h3000,  9, -1, 0, 12'h0, 16'h05A5, 16'hFF80, 1'b0, 3'd5},
         '{16'h2800, 16, -1, 0, 12'h0, 16'h05A5, 16'hFFFF, 1'b1, 3'd5}};
      run_table("abort", tab);
   endtask

   task automatic test_reserved();
      vec_t tab[] = '{
         '{16'hE000, 16, -1, 0, 12'h0, 16'h05A5, 16'hFFFF, 1'b0, 3'd5},
         '{16'h3000, 17, -1, 0, 12'h0, 16'h05A5, 16'hFFFF, 1'b0, 3'd5}};
      run_table("reserved", tab);
   endtask

   task automatic test_data_change();
      vec_t tab[] = '{
         '{16'h2000, 16,  5, 5, 12'hFFF, 16'h05A5, 16'hFFFF, 1'b1, 3'd4},
         '{16'h3800, 16, -1, 0, 12'h0,   16'h0123, 16'hFFFF, 1'b1, 3'd7}};
      run_table("datachg", tab);
   endtask

   task automatic test_reset_midframe();
      int   v0, e0;
      logic acc;
      vec_t tab[] = '{
         '{16'h2000, 16, -1, 0, 12'h0, 16'h0ABC, 16'hFFFF, 1'b1, 3'd4}};
      v0 = vld_cnt; e0 = err_cnt;
      SS_n = 1'b0; MOSI = 1'b0;
      tick(6);
      repeat (3) sclk_cycle();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      n_vec++;
      if (cmd_ch !== 3'd0) begin
         n_bad++;
         $display("FAIL rstmid cmd_ch got %0d want 0", cmd_ch);
      end
      acc = MISO;
      for (int i = 0; i < 5; i++) begin
         SCLK = 1'b0; MOSI = i[0]; tick(6);
         acc = acc | MISO;
         SCLK = 1'b1; tick(6);
         acc = acc | MISO;
      end
      SS_n = 1'b1;
      tick(12);
      n_vec++;
      if (acc !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid MISO got %b want 0", acc);
      end
      n_vec++;
      if (vld_cnt !== v0 || err_cnt !== e0) begin
         n_bad++;
         $display("FAIL rstmid pulses got vld+%0d err+%0d want 0 0", vld_cnt - v0, err_cnt - e0);
      end
      run_table("rstmid", tab);
   endtask

   task automatic test_pulses();
      n_vec++;
      if (both_cnt !== 0 || long_cnt !== 0) begin
         n_bad++;
         $display("FAIL pulses both=%0d long=%0d want 0 0", both_cnt, long_cnt);
      end
      n_vec++;
      if (vld_cnt !== 6 || err_cnt !== 3) begin
         n_bad++;
         $display("FAIL totals vld=%0d err=%0d want 6 3", vld_cnt, err_cnt);
      end
   endtask

   initial begin
      chan_data = '0;
      for (int c = 0; c < 8; c++) set_ch(c, 12'h111 * c[11:0]);
      set_ch(0, 12'hABC);
      set_ch(4, 12'h123);
      set_ch(5, 12'h5A5);
      test_reset();
      test_command();
      test_abort();
      test_reserved();
      test_data_change();
      test_reset_midframe();
      test_pulses();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 Parameter FIRST_CH, default 3'b000: channel whose sample is returned in the first frame after reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 SS_n  input  1  SPI select from initiator, asynchronous to clk, active-low.
REQ-005 SCLK  input  1  SPI clock from initiator, asynchronous to clk, idles high.
REQ-006 MOSI  input  1  command bit from initiator, MSB first.
REQ-007 MISO  output  1  response bit to initiator, MSB first; 0 when not selected.
REQ-008 chan_data  input  96  eight 12-bit analog samples; channel n at bits [12n+11:12n].
REQ-009 cmd_ch  output  3  channel latched from the last accepted command.
REQ-010 cmd_vld  output  1  one-clk pulse when a command is accepted.
REQ-011 frame_err  output  1  one-clk pulse when a frame ends with bit count != 16 or reserved bits != 00.

Function
REQ-012 SS_n, SCLK, MOSI SHALL each pass through a 2-flop synchronizer plus a third history flop; edges are detected from the 2nd/3rd flops.
REQ-013 All outputs SHALL be registered; any response to a raw SS_n/SCLK edge SHALL appear exactly 3 clk after that edge.
REQ-014 FSM states SHALL be IDLE, ARMED, SHIFT; reset enters IDLE.
REQ-015 IDLE -> ARMED when synced SS_n is high; ensures a frame already in progress at reset release is ignored.
REQ-016 ARMED -> SHIFT on synced SS_n fall: tx shift register loaded with {4'h0, chan_data sample of cmd_ch}, bit counter cleared.
REQ-017 Sample value SHALL be captured at the load instant and held for the whole frame even if chan_data changes.
REQ-018 In SHIFT, on each synced SCLK rise: MOSI shifted into 16-bit rx register LSB end; counter increments, saturating at 17.
REQ-019 In SHIFT, on each synced SCLK fall that follows at least one rise: tx register shifts left, 0 filled; MISO = tx[15] while SS_n low.
REQ-020 SCLK falls with counter = 0 (pre-first-rise) SHALL NOT shift tx.
REQ-021 SHIFT -> ARMED on synced SS_n rise; at that clock the frame is evaluated.
REQ-022 Valid frame: counter == 16 and rx[15:14] == 2'b00 -> cmd_ch <= rx[13:11], cmd_vld pulses; rx[10:0] ignored.
REQ-023 Invalid frame (counter < 16, counter == 17, or rx[15:14] != 00) -> frame_err pulses, cmd_ch unchanged.
REQ-024 cmd_vld and frame_err SHALL never assert in the same cycle.
REQ-025 Response protocol: the frame after an accepted command returns that channel's sample; the frame carrying the command returns the sample for the previous cmd_ch.
REQ-026 SCLK edge coincident with SS_n rise in the same synced cycle: SS_n rise takes priority; edge ignored.
REQ-027 Initiator SHALL hold >=4 clk between SS_n fall and first SCLK fall and SCLK half-period >=4 clk; behaviour outside this is undefined.

Reset
REQ-028 On rst_n low at a clk rise: FSM = IDLE, cmd_ch = FIRST_CH, cmd_vld = 0, frame_err = 0, MISO = 0, rx/tx/counter = 0.
REQ-029 SS_n and SCLK synchronizer flops SHALL reset to 1; MOSI flops to 0.
REQ-030 Reset mid-frame SHALL abort the frame with no cmd_vld or frame_err pulse; the next frame begins only after SS_n is seen high.

Verification
REQ-031 After reset, chan_data ch0 = 12'hABC; one 16-bit frame with MOSI 16'h2000 -> MISO returns 16'h0ABC, cmd_vld pulses, cmd_ch = 3'b100.
REQ-032 Following frame with ch4 = 12'h123, MOSI 16'h2800 -> MISO 16'h0123, cmd_ch = 3'b101.
REQ-033 Frame aborted after 9 SCLK cycles -> frame_err pulses once, cmd_ch unchanged, next frame still returns the prior channel's value.
REQ-034 Frame with MOSI 16'hE000 (reserved bits 11) -> frame_err, cmd_ch unchanged; 17-clock frame -> frame_err.
REQ-035 chan_data changed mid-frame -> MISO still returns the value sampled at SS_n fall.
REQ-036 rst_n asserted mid-frame with SS_n low, released while SS_n still low -> no pulses, MISO = 0, the remainder of the frame ignored, the next full frame after SS_n high returns the FIRST_CH sample.
